as2650_bus_seq: RTL and testbench

- Bus sequencer between the AS2650 core and the external multiplexed 8-bit memory bus.
- Converts each single-transfer request from the core (16-bit address, read or write) into the pin sequence the external latches and memory expect:
  - ADDR_HI phase with le_hi.
  - ADDR_LO phase with le_lo.
  - DATA phase with OEb (read) or WEb (write).
- Caches the last high address byte so the ADDR_HI phase can be skipped.

---
 rtl/as2650_bus_seq.sv | 206 ++++++++++++++++++++
 tb/tb_as2650_bus_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/as2650_bus_seq.sv
// AS2650 core to multiplexed 8-bit memory bus sequencer: ADDR_HI / ADDR_LO / DATA phases, 3 cycles + rdy wait
// (2 on a high-byte hit when AS2650_HI_CACHE_EN is defined); rdy=0 stretches DATA, req is only taken in IDLE with ack low.
module as2650_bus_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rdy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oeb,
  output logic              le_hi,
  output logic              le_lo,
  output logic              OEb,
  output logic              WEb
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    DATA    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              bus_oeb_q, bus_oeb_d;
  logic              oeb_q, oeb_d;
  logic              web_q, web_d;
  logic              le_hi_set_q, le_hi_set_d;
  logic              le_lo_set_q, le_lo_set_d;
  logic              le_hi_clr_q, le_hi_clr_d;
  logic              le_lo_clr_q, le_lo_clr_d;

  logic              accept;
  logic              hi_miss;
  logic [ADDR_W-1:0] cur_addr;

  // The ack cycle is never an accept cycle, so a held req cannot replay the finished transfer.
  assign accept   = (state_q == IDLE) && req && !ack_q;
  assign cur_addr = (state_q == IDLE) ? addr : addr_q;

`ifdef AS2650_HI_CACHE_EN
  logic [7:0] hi_cache_q, hi_cache_d;
  logic       hi_valid_q, hi_valid_d;

  assign hi_miss = !hi_valid_q || (addr[ADDR_W-1:8] != hi_cache_q);

  always_comb begin
    hi_cache_d = hi_cache_q;
    hi_valid_d = hi_valid_q;
    if (state_d == ADDR_HI) begin
      hi_cache_d = cur_addr[ADDR_W-1:8];
      hi_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cache_q <= 8'h00;
      hi_valid_q <= 1'b0;
    end else begin
      hi_cache_q <= hi_cache_d;
      hi_valid_q <= hi_valid_d;
    end
  end
`else
  assign hi_miss = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = hi_miss ? ADDR_HI : ADDR_LO;
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: state_d = DATA;
      DATA:    if (rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad values are computed for the state being entered so every pin comes straight off a flop.
  always_comb begin
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    bus_out_d   = bus_out_q;
    bus_oeb_d   = 1'b1;
    oeb_d       = 1'b1;
    web_d       = 1'b1;
    le_hi_set_d = 1'b0;
    le_lo_set_d = 1'b0;

    if (accept) begin
      addr_d  = addr;
      we_d    = we;
      wdata_d = wdata;
    end

    if (state_q == DATA && rdy) begin
      ack_d = 1'b1;
      if (!we_q) rdata_d = bus_in;
    end

    case (state_d)
      ADDR_HI: begin
        bus_out_d   = cur_addr[ADDR_W-1:8];
        bus_oeb_d   = 1'b0;
        le_hi_set_d = 1'b1;
      end
      ADDR_LO: begin
        bus_out_d   = cur_addr[7:0];
        bus_oeb_d   = 1'b0;
        le_lo_set_d = 1'b1;
      end
      DATA: begin
        if (we_q) begin
          bus_out_d = wdata_q;
          bus_oeb_d = 1'b0;
          web_d     = 1'b0;
        end else begin
          oeb_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      bus_out_q   <= '0;
      bus_oeb_q   <= 1'b1;
      oeb_q       <= 1'b1;
      web_q       <= 1'b1;
      le_hi_set_q <= 1'b0;
      le_lo_set_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      bus_out_q   <= bus_out_d;
      bus_oeb_q   <= bus_oeb_d;
      oeb_q       <= oeb_d;
      web_q       <= web_d;
      le_hi_set_q <= le_hi_set_d;
      le_lo_set_q <= le_lo_set_d;
    end
  end

  // The clear flops follow the set flops half a cycle late, cutting each latch enable to a
  // half-cycle pulse while the address itself stays on the bus for the full cycle.
  always_comb begin
    le_hi_clr_d = le_hi_set_q;
    le_lo_clr_d = le_lo_set_q;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      le_hi_clr_q <= 1'b0;
      le_lo_clr_q <= 1'b0;
    end else begin
      le_hi_clr_q <= le_hi_clr_d;
      le_lo_clr_q <= le_lo_clr_d;
    end
  end

  assign le_hi   = le_hi_set_q & ~le_hi_clr_q;
  assign le_lo   = le_lo_set_q & ~le_lo_clr_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign bus_out = bus_out_q;
  assign bus_oeb = bus_oeb_q;
  assign OEb     = oeb_q;
  assign WEb     = web_q;

endmodule

// File: tb/tb_as2650_bus_seq.sv
// Directed bench for as2650_bus_seq; expectations follow AS2650_HI_CACHE_EN when it is defined.
module tb_as2650_bus_seq;

`ifdef AS2650_HI_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we, rdy;
  logic [15:0] addr;
  logic [7:0]  wdata, bus_in;
  logic        ack, bus_oeb, le_hi, le_lo, OEb, WEb;
  logic [7:0]  rdata, bus_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  as2650_bus_seq dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdy(rdy), .ack(ack), .rdata(rdata), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oeb(bus_oeb), .le_hi(le_hi), .le_lo(le_lo), .OEb(OEb), .WEb(WEb)
  );

  typedef struct {
    string       name;
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  bi;
    int          wait_n;
    logic        exp_hi;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transfer; samples 1 time unit after each posedge and checks the le pulse is gone by the negedge.
  task automatic do_xfer(input vec_t v);
    int         dc = 0, oe_n = 0, we_n = 0, lat = -1;
    logic       hi_seen = 1'b0, lo_seen = 1'b0, done = 1'b0;
    logic       wbus_ok = 1'b1, rbus_ok = 1'b1, neg_ok = 1'b1, excl_ok = 1'b1, addr_oe_ok = 1'b1;
    logic [7:0] hi_v = 8'h00, lo_v = 8'h00, rd = 8'h00;
    req = 1'b1; we = v.w; addr = v.a; wdata = v.d; rdy = 1'b0; bus_in = 8'hEE;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 24 && !done; k++) begin
      if (le_hi) begin hi_seen = 1'b1; hi_v = bus_out; if (bus_oeb) addr_oe_ok = 1'b0; end
      if (le_lo) begin lo_seen = 1'b1; lo_v = bus_out; if (bus_oeb) addr_oe_ok = 1'b0; end
      if (!OEb && !WEb) excl_ok = 1'b0;
      if (!OEb) begin oe_n++; if (!bus_oeb) rbus_ok = 1'b0; end
      if (!WEb) begin we_n++; if (bus_out !== v.d || bus_oeb || !OEb) wbus_ok = 1'b0; end
      if (ack) begin done = 1'b1; lat = k; rd = rdata; end
      if (!OEb || !WEb) dc++;
      rdy    = (dc > v.wait_n);
      bus_in = rdy ? v.bi : 8'hE0 + 8'(dc);
      #5;
      if (le_hi || le_lo) neg_ok = 1'b0;
      if (!done) begin @(posedge clk); #1; end
    end
    rdy = 1'b0;
    chk({v.name, " ack_seen"}, 32'(done), 32'd1);
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " le_hi_seen"}, 32'(hi_seen), 32'(v.exp_hi));
    if (v.exp_hi) chk({v.name, " hi_addr"}, 32'(hi_v), 32'(v.a[15:8]));
    chk({v.name, " le_lo_seen"}, 32'(lo_seen), 32'd1);
    chk({v.name, " lo_addr"}, 32'(lo_v), 32'(v.a[7:0]));
    chk({v.name, " addr_drive"}, 32'(addr_oe_ok), 32'd1);
    chk({v.name, " le_negedge_clear"}, 32'(neg_ok), 32'd1);
    chk({v.name, " oeb_web_excl"}, 32'(excl_ok), 32'd1);
    chk({v.name, " oeb_cycles"}, 32'(oe_n), v.w ? 32'd0 : 32'(v.wait_n + 1));
    chk({v.name, " web_cycles"}, 32'(we_n), v.w ? 32'(v.wait_n + 1) : 32'd0);
    if (v.w) chk({v.name, " write_bus"}, 32'(wbus_ok), 32'd1);
    else begin
      chk({v.name, " read_bus_released"}, 32'(rbus_ok), 32'd1);
      chk({v.name, " rdata"}, 32'(rd), 32'(v.bi));
    end
    @(posedge clk); #1;
    chk({v.name, " ack_one_cycle"}, 32'(ack), 32'd0);
  endtask

  initial begin
    int         ack_k, hi_k, k;
    logic       bad_ack;
    logic [7:0] hv;

    vecs[0] = '{"rd0000",   1'b0, 16'h0000, 8'h00, 8'h04, 0, 1'b1,   3};
    vecs[1] = '{"rd0001",   1'b0, 16'h0001, 8'h00, 8'h3C, 0, !CACHE, CACHE ? 2 : 3};
    vecs[2] = '{"wr0FA0",   1'b1, 16'h0FA0, 8'h58, 8'h00, 0, 1'b1,   3};
    vecs[3] = '{"rd4C87w3", 1'b0, 16'h4C87, 8'h00, 8'h9A, 3, 1'b1,   6};
    vecs[4] = '{"rd4C10",   1'b0, 16'h4C10, 8'h00, 8'h11, 0, !CACHE, CACHE ? 2 : 3};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; rdy = 1'b0; bus_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst le_hi", 32'(le_hi), 32'd0);
    chk("rst le_lo", 32'(le_lo), 32'd0);
    chk("rst OEb", 32'(OEb), 32'd1);
    chk("rst WEb", 32'(WEb), 32'd1);
    chk("rst bus_out", 32'(bus_out), 32'h00);
    chk("rst bus_oeb", 32'(bus_oeb), 32'd1);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst rdata", 32'(rdata), 32'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

    // Back-to-back with req held: the ack cycle is the only dead IDLE cycle, the next
    // accept happens one edge later, so the second le_hi rises two edges after ack.
    req = 1'b1; we = 1'b0; addr = 16'h00FF; rdy = 1'b1; bus_in = 8'hA5;
    ack_k = -1; hi_k = -1; hv = 8'h00; k = 0;
    @(posedge clk); #1;
    while (k < 30 && ack_k < 0) begin
      if (ack) begin
        ack_k = k;
        chk("b2b first rdata", 32'(rdata), 32'hA5);
        addr = 16'h0100; bus_in = 8'h5A;
      end else begin
        @(posedge clk); #1; k++;
      end
    end
    while (k < 30 && hi_k < 0) begin
      @(posedge clk); #1; k++;
      if (le_hi) begin hi_k = k; hv = bus_out; end
    end
    chk("b2b ack_to_le_hi", 32'(hi_k - ack_k), 32'd2);
    chk("b2b hi_addr", 32'(hv), 32'h01);
    ack_k = -1;
    while (k < 40 && ack_k < 0) begin
      @(posedge clk); #1; k++;
      if (ack) ack_k = k;
    end
    req = 1'b0;
    chk("b2b second ack", 32'(ack_k > 0), 32'd1);
    chk("b2b second rdata", 32'(rdata), 32'h5A);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a write sits in DATA waiting on rdy.
    req = 1'b1; we = 1'b1; addr = 16'h2233; wdata = 8'h77; rdy = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    k = 0;
    while (k < 10 && WEb) begin @(posedge clk); #1; k++; end
    chk("rstmid reached DATA", 32'(WEb), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid WEb", 32'(WEb), 32'd1);
    chk("rstmid bus_oeb", 32'(bus_oeb), 32'd1);
    chk("rstmid ack", 32'(ack), 32'd0);
    rst = 1'b0; rdy = 1'b1;
    bad_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (ack || !WEb) bad_ack = 1'b1; end
    rdy = 1'b0;
    chk("rstmid no_ack", 32'(bad_ack), 32'd0);
    do_xfer('{"rd2244_postrst", 1'b0, 16'h2244, 8'h00, 8'hC3, 0, 1'b1, 3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
